// File: rtl/cfg_pwm_timer_pkg.sv
// Shared types and register-map constants for the cfg_pwm_timer block.
package cfg_pwm_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CFG_CTRL    = 0;
    localparam int CFG_PER_LO  = 1;
    localparam int CFG_PER_HI  = 2;
    localparam int CFG_DUTY_LO = 3;
    localparam int CFG_DUTY_HI = 4;

    localparam int ST_CNT_LO = 0;
    localparam int ST_CNT_HI = 1;
    localparam int ST_WRAP   = 2;
    localparam int ST_FLAGS  = 3;
    localparam int ST_ID     = 4;
    localparam int ST_VER    = 5;

    localparam int CTRL_ENABLE    = 0;
    localparam int CTRL_ONE_SHOT  = 1;
    localparam int CTRL_CLEAR     = 2;
    localparam int CTRL_INVERT    = 3;
    localparam int CTRL_PRESC_LSB = 4;

    localparam logic [7:0] TIMER_ID  = 8'hC5;
    localparam logic [7:0] TIMER_VER = 8'h01;

endpackage

// File: rtl/cfg_pwm_timer_prescaler.sv
// Power-of-two prescaler: one-clk tick every 2^n enabled clocks while running.
module cfg_pwm_prescaler (
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic       run,
    input  logic       clear,
    input  logic [3:0] n,
    output logic       tick
);

    logic [14:0] cnt;
    logic [14:0] mask;

    // n=15 shifts the one out of range; the subtraction then wraps to 2^15-1.
    always_comb begin
        mask = (15'd1 << n) - 15'd1;
        tick = run && (cnt == mask);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (ena) begin
            if (!run || clear || tick) cnt <= '0;
            else                       cnt <= cnt + 15'd1;
        end
    end

endmodule

// File: rtl/cfg_pwm_timer.sv
// Register-mapped 16-bit PWM timer fed by the SPI config bus.
// Optional: CFG_PWM_TIMER_SHADOW_EN captures period/duty into shadow registers.
module cfg_pwm_timer
    import cfg_pwm_timer_pkg::*;
#(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            pwm_out
);

    logic [7:0]  ctrl;
    logic [15:0] period_cfg, duty_cfg, period_eff, duty_eff;
    logic        enable, one_shot, invert, clear_edge;
    logic        tick, run, wrap, load_sh;
    logic        clear_d, done, wrap_sticky;
    logic [15:0] count;
    logic [7:0]  wrap_cnt;
    state_t      state, state_nxt;
    logic        unused_cfg;

    assign ctrl       = config_regs[CFG_CTRL*REG_WIDTH +: REG_WIDTH];
    assign period_cfg = {config_regs[CFG_PER_HI*REG_WIDTH +: REG_WIDTH],
                         config_regs[CFG_PER_LO*REG_WIDTH +: REG_WIDTH]};
    assign duty_cfg   = {config_regs[CFG_DUTY_HI*REG_WIDTH +: REG_WIDTH],
                         config_regs[CFG_DUTY_LO*REG_WIDTH +: REG_WIDTH]};
    assign unused_cfg = ^config_regs[NUM_CFG*REG_WIDTH-1:5*REG_WIDTH];

    assign enable     = ctrl[CTRL_ENABLE];
    assign one_shot   = ctrl[CTRL_ONE_SHOT];
    assign invert     = ctrl[CTRL_INVERT];
    assign clear_edge = ctrl[CTRL_CLEAR] & ~clear_d;
    assign run        = (state == RUN);

`ifdef CFG_PWM_TIMER_SHADOW_EN
    logic [15:0] period_sh, duty_sh;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            period_sh <= '0;
            duty_sh   <= '0;
        end else if (ena && load_sh) begin
            period_sh <= period_cfg;
            duty_sh   <= duty_cfg;
        end
    end

    assign period_eff = period_sh;
    assign duty_eff   = duty_sh;
`else
    assign period_eff = period_cfg;
    assign duty_eff   = duty_cfg;
`endif

    cfg_pwm_prescaler u_prescaler (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .run   (run),
        .clear (clear_edge),
        .n     (ctrl[CTRL_PRESC_LSB +: 4]),
        .tick  (tick)
    );

    // A clear edge suppresses any wrap landing on the same cycle.
    assign wrap = run && tick && !clear_edge && (count == period_eff);

    always_comb begin
        state_nxt = state;
        load_sh   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    load_sh   = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (one_shot) state_nxt = DONE;
                    else          load_sh   = 1'b1;
                end
                if (!enable) state_nxt = IDLE;
            end
            DONE: begin
                if (clear_edge || !enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            clear_d     <= 1'b0;
            count       <= '0;
            wrap_cnt    <= '0;
            done        <= 1'b0;
            wrap_sticky <= 1'b0;
            pwm_out     <= 1'b0;
        end else if (ena) begin
            state   <= state_nxt;
            clear_d <= ctrl[CTRL_CLEAR];
            pwm_out <= run ? ((count < duty_eff) ^ invert) : invert;
            if (clear_edge) begin
                count       <= '0;
                wrap_cnt    <= '0;
                done        <= 1'b0;
                wrap_sticky <= 1'b0;
            end else if (state == DONE) begin
                count <= '0;
            end else if (wrap) begin
                count       <= '0;
                wrap_sticky <= 1'b1;
                if (wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
                if (one_shot)          done     <= 1'b1;
            end else if (run && tick) begin
                count <= count + 16'd1;
            end
        end
    end

    always_comb begin
        status_regs = '0;
        status_regs[ST_CNT_LO*REG_WIDTH +: REG_WIDTH] = count[7:0];
        status_regs[ST_CNT_HI*REG_WIDTH +: REG_WIDTH] = count[15:8];
        status_regs[ST_WRAP*REG_WIDTH   +: REG_WIDTH] = wrap_cnt;
        status_regs[ST_FLAGS*REG_WIDTH  +: REG_WIDTH] = {4'b0000, wrap_sticky, pwm_out, done, run};
        status_regs[ST_ID*REG_WIDTH     +: REG_WIDTH] = TIMER_ID;
        status_regs[ST_VER*REG_WIDTH    +: REG_WIDTH] = TIMER_VER;
    end

endmodule

// File: tb/tb_cfg_pwm_timer.sv
// Directed, table-driven bench for cfg_pwm_timer with hand-computed expectations.
module tb_cfg_pwm_timer;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        ena = 1'b1;
    logic [63:0] config_regs = '0;
    logic [63:0] status_regs;
    logic        pwm_out;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [63:0] RESET_STATUS = 64'h0000_01C5_0000_0000;

    cfg_pwm_timer dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cfg0;
        logic [15:0] period;
        logic [15:0] duty;
        int          cycles;
        logic [15:0] exp_count;
        logic [7:0]  exp_wrap;
        logic [7:0]  exp_st3;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] cfg0, input logic [15:0] period, input logic [15:0] duty);
        config_regs = {24'h0, duty, period, cfg0};
    endtask

    // Advance n rising edges, returning at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    initial begin
        //          cfg0   period    duty     cyc  count     wrap   st3
        vecs[0]  = '{8'h01, 16'd4,   16'd2,   1,   16'd0,    8'd0,  8'h01};
        vecs[1]  = '{8'h01, 16'd4,   16'd2,   2,   16'd1,    8'd0,  8'h05};
        vecs[2]  = '{8'h01, 16'd4,   16'd2,   4,   16'd3,    8'd0,  8'h01};
        vecs[3]  = '{8'h01, 16'd4,   16'd2,   6,   16'd0,    8'd1,  8'h09};
        vecs[4]  = '{8'h01, 16'd4,   16'd2,   7,   16'd1,    8'd1,  8'h0D};
        vecs[5]  = '{8'h01, 16'd0,   16'd0,   5,   16'd0,    8'd4,  8'h09};
        vecs[6]  = '{8'h01, 16'd3,   16'd5,   3,   16'd2,    8'd0,  8'h05};
        vecs[7]  = '{8'h09, 16'd4,   16'd2,   3,   16'd2,    8'd0,  8'h01};
        vecs[8]  = '{8'h09, 16'd4,   16'd0,   4,   16'd3,    8'd0,  8'h05};
        vecs[9]  = '{8'h11, 16'd4,   16'd2,   6,   16'd2,    8'd0,  8'h01};
        vecs[10] = '{8'h00, 16'd4,   16'd2,   5,   16'd0,    8'd0,  8'h00};

        // Reset state
        set_cfg(8'h00, 16'h0000, 16'h0000);
        do_reset();
        step(1);
        check("reset_status", status_regs, RESET_STATUS);
        check("reset_pwm", {63'd0, pwm_out}, 64'd0);

        // Table-driven vectors, each from a fresh reset
        for (int i = 0; i < 11; i++) begin
            set_cfg(vecs[i].cfg0, vecs[i].period, vecs[i].duty);
            do_reset();
            step(vecs[i].cycles);
            check($sformatf("vec%0d_count", i), {48'd0, status_regs[15:0]}, {48'd0, vecs[i].exp_count});
            check($sformatf("vec%0d_wrap", i), {56'd0, status_regs[23:16]}, {56'd0, vecs[i].exp_wrap});
            check($sformatf("vec%0d_st3", i), {56'd0, status_regs[31:24]}, {56'd0, vecs[i].exp_st3});
            check($sformatf("vec%0d_pin", i), {63'd0, pwm_out}, {63'd0, vecs[i].exp_st3[2]});
        end

        // Cycle-by-cycle count and pwm sequence, period 4 duty 2
        set_cfg(8'h01, 16'd4, 16'd2);
        do_reset();
        step(1);
        for (int k = 2; k <= 16; k++) begin
            step(1);
            check($sformatf("seq%0d_count", k), {48'd0, status_regs[15:0]}, 64'((k - 1) % 5));
            check($sformatf("seq%0d_pwm", k), {63'd0, pwm_out}, {63'd0, ((k - 2) % 5) < 2});
            check($sformatf("seq%0d_wrap", k), {56'd0, status_regs[23:16]}, 64'((k - 1) / 5));
        end

        // One-shot with prescale n=2, period 1
        set_cfg(8'h23, 16'd1, 16'd1);
        do_reset();
        step(8);
        check("oneshot_pre_count", {48'd0, status_regs[15:0]}, 64'd1);
        check("oneshot_pre_st3", {56'd0, status_regs[31:24]}, 64'h01);
        step(1);
        check("oneshot_done_st3", {56'd0, status_regs[31:24]}, 64'h0A);
        check("oneshot_done_count", {48'd0, status_regs[15:0]}, 64'd0);
        check("oneshot_done_wrap", {56'd0, status_regs[23:16]}, 64'd1);
        check("oneshot_done_pin", {63'd0, pwm_out}, 64'd0);
        set_cfg(8'h22, 16'd1, 16'd1);
        step(1);
        check("oneshot_idle_st3", {56'd0, status_regs[31:24]}, 64'h0A);
        set_cfg(8'h26, 16'd1, 16'd1);
        step(1);
        check("oneshot_clear_status", status_regs, RESET_STATUS);

        // Byte-wise period update while running
        set_cfg(8'h01, 16'h00FF, 16'd0);
        do_reset();
        step(17);
        check("shadow_start_count", {48'd0, status_regs[15:0]}, 64'h10);
        set_cfg(8'h01, 16'h01FF, 16'd0);
        step(16'hF0);
`ifdef CFG_PWM_TIMER_SHADOW_EN
        check("shadow_first_count", {48'd0, status_regs[15:0]}, 64'h0);
        check("shadow_first_wrap", {56'd0, status_regs[23:16]}, 64'd1);
        step(16'h100);
        check("shadow_second_count", {48'd0, status_regs[15:0]}, 64'h100);
        check("shadow_second_wrap", {56'd0, status_regs[23:16]}, 64'd1);
`else
        check("live_first_count", {48'd0, status_regs[15:0]}, 64'h100);
        check("live_first_wrap", {56'd0, status_regs[23:16]}, 64'd0);
        step(16'h100);
        check("live_second_count", {48'd0, status_regs[15:0]}, 64'h0);
        check("live_second_wrap", {56'd0, status_regs[23:16]}, 64'd1);
`endif

        // wrap_cnt saturation, then clear on a wrap cycle
        set_cfg(8'h01, 16'd0, 16'd0);
        do_reset();
        step(300);
        check("sat_wrap", {56'd0, status_regs[23:16]}, 64'd255);
        check("sat_st3", {56'd0, status_regs[31:24]}, 64'h09);
        set_cfg(8'h05, 16'd0, 16'd0);
        step(1);
        check("clr_wrap", {56'd0, status_regs[23:16]}, 64'd0);
        check("clr_count", {48'd0, status_regs[15:0]}, 64'd0);
        check("clr_st3", {56'd0, status_regs[31:24]}, 64'h01);
        step(1);
        check("after_clr_wrap", {56'd0, status_regs[23:16]}, 64'd1);

        // ena freeze mid-run, with a clear pulse hidden inside the freeze
        set_cfg(8'h01, 16'd4, 16'd2);
        do_reset();
        step(7);
        check("frz_before", status_regs, 64'h0000_01C5_0D01_0001);
        ena = 1'b0;
        set_cfg(8'h05, 16'd4, 16'd2);
        step(5);
        set_cfg(8'h01, 16'd4, 16'd2);
        step(5);
        check("frz_status", status_regs, 64'h0000_01C5_0D01_0001);
        check("frz_pin", {63'd0, pwm_out}, 64'd1);
        ena = 1'b1;
        step(1);
        check("frz_resume_count", {48'd0, status_regs[15:0]}, 64'd2);
        check("frz_resume_wrap", {56'd0, status_regs[23:16]}, 64'd1);

        // Asynchronous reset mid-run
        step(2);
        rstb = 1'b0;
        #1;
        check("async_rst_status", status_regs, RESET_STATUS);
        check("async_rst_pin", {63'd0, pwm_out}, 64'd0);
        step(1);
        rstb = 1'b1;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
